spi_sclk_gen: RTL

SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

---
 rtl/spi_sclk_gen_if.sv | 29 ++
 rtl/spi_sclk_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/spi_sclk_gen_if.sv
// Control/status bundle for the SPI serial-clock generator.
// The master side drives the transfer request; the slave side returns SCLK and the timing strobes.
interface spi_sclk_gen_if #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 6
) ();
  logic              go;
  logic              abort;
  logic [DIV_W-1:0]  divider;
  logic [BITS_W-1:0] nbits;
  logic              cpol;
  logic              cpha;
  logic              sclk;
  logic              sample;
  logic              shift;
  logic              busy;
  logic              done;
  logic [BITS_W-1:0] bit_cnt;

  modport master (
    output go, abort, divider, nbits, cpol, cpha,
    input  sclk, sample, shift, busy, done, bit_cnt
  );

  modport slave (
    input  go, abort, divider, nbits, cpol, cpha,
    output sclk, sample, shift, busy, done, bit_cnt
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period, CPOL/CPHA strobes,
// a trailing quiet half-period (TAIL) before done, and abort. All outputs registered.
module spi_sclk_gen #(
  parameter int DIV_W  = 8,
  parameter int BITS_W = 6
) (
  input  logic          clk_in,
  input  logic          rst,
  spi_sclk_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TAIL} state_t;

  state_t            r_state, w_state;
  logic [DIV_W-1:0]  r_div, w_div;
  logic [BITS_W-1:0] r_nbits, w_nbits;
  logic              r_cpol, w_cpol;
  logic              r_cpha, w_cpha;
  logic [DIV_W-1:0]  r_cnt, w_cnt;
  logic              r_lead, w_lead;
  logic              r_sclk, w_sclk;
  logic              r_sample, w_sample;
  logic              r_shift, w_shift;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic [BITS_W-1:0] r_bit_cnt, w_bit_cnt;
  logic [BITS_W-1:0] w_bc_inc;

  assign w_bc_inc = r_bit_cnt + 1'b1;

  // r_lead set means a leading edge has been issued and the next toggle is trailing.
  always_comb begin
    w_state   = r_state;
    w_div     = r_div;
    w_nbits   = r_nbits;
    w_cpol    = r_cpol;
    w_cpha    = r_cpha;
    w_cnt     = r_cnt;
    w_lead    = r_lead;
    w_sclk    = r_sclk;
    w_sample  = 1'b0;
    w_shift   = 1'b0;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_bit_cnt = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        w_sclk = bus.cpol;
        w_busy = 1'b0;
        if (bus.go && !bus.abort) begin
          w_div     = bus.divider;
          w_nbits   = bus.nbits;
          w_cpol    = bus.cpol;
          w_cpha    = bus.cpha;
          w_cnt     = bus.divider;
          w_lead    = 1'b0;
          w_bit_cnt = '0;
          w_busy    = 1'b1;
          w_state   = (bus.nbits == '0) ? S_TAIL : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_sclk  = r_cpol;
        end else if (r_cnt == '0) begin
          w_cnt  = r_div;
          w_sclk = ~r_sclk;
          if (!r_lead) begin
            w_lead = 1'b1;
            if (r_cpha) w_shift  = 1'b1;
            else        w_sample = 1'b1;
          end else begin
            w_lead    = 1'b0;
            w_bit_cnt = w_bc_inc;
            // CPHA=0 has no launch after the final bit.
            if (r_cpha) w_sample = 1'b1;
            else        w_shift  = (w_bc_inc != r_nbits);
            if (w_bc_inc == r_nbits) w_state = S_TAIL;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_TAIL: begin
        if (bus.abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_sclk  = r_cpol;
        end else if (r_cnt == '0) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_sclk  = r_cpol;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_nbits   <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_cnt     <= '1;
      r_lead    <= 1'b0;
      r_sclk    <= 1'b0;
      r_sample  <= 1'b0;
      r_shift   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_nbits   <= w_nbits;
      r_cpol    <= w_cpol;
      r_cpha    <= w_cpha;
      r_cnt     <= w_cnt;
      r_lead    <= w_lead;
      r_sclk    <= w_sclk;
      r_sample  <= w_sample;
      r_shift   <= w_shift;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_bit_cnt <= w_bit_cnt;
    end
  end

  assign bus.sclk    = r_sclk;
  assign bus.sample  = r_sample;
  assign bus.shift   = r_shift;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bit_cnt = r_bit_cnt;

endmodule
